// File: rtl/weight_sram_bank_ctrl.sv
// ---------------------------------------------------------------------------
// weight_sram_bank_ctrl
//
// Parametrised weight SRAM bank that sits between the weight-load DMA and the
// CIM macro weight-fetch logic. It has two sides:
//   * Burst loader: the host starts a burst (load_start, load_base, load_len)
//     and then streams words over a valid/ready handshake into consecutive
//     addresses, wrapping at DEPTH. Per-segment masks allow partial row
//     updates. load_done pulses for one cycle when the burst completes.
//   * Read port: single-word reads with a fully pipelined RD_LAT-cycle
//     latency. Reads are accepted only while the loader is idle.
//
// Ports
//   clk, rst_n             clock and asynchronous active-low reset
//   load_start             start a burst (honoured only in IDLE)
//   load_base, load_len    first address and word count of the burst
//   wr_valid, wr_ready     write-beat handshake
//   wr_data, wr_mask       write word and per-segment enables
//   load_done              one-cycle completion pulse
//   busy                   loader is not idle
//   rd_req, rd_addr        read request and address
//   rd_ready               read request is accepted this cycle
//   rd_valid, rd_data      read response (rd_data holds when rd_valid is low)
//
// Memory contents are not reset and are retained across reset.
// ---------------------------------------------------------------------------
module weight_sram_bank_ctrl #(
    parameter int unsigned DATA_W = 30,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned SEG_W  = 6,
    parameter int unsigned RD_LAT = 1,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned NSEG   = DATA_W / SEG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NSEG-1:0]   wr_mask,
    output logic              load_done,
    output logic              busy,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              wr_ready_q;
    logic              load_done_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_beat;
    logic [ADDR_W-1:0] base_fix;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              rd_accept;
    logic [DATA_W-1:0] rd_word;

    // -----------------------------------------------------------------------
    // Loader FSM
    // -----------------------------------------------------------------------
    always_comb begin
        wr_beat  = (state_q == StLoad) && wr_valid && wr_ready_q;
        // Out-of-range bases only exist for non-power-of-2 DEPTH.
        base_fix = (32'(load_base) >= DEPTH) ? '0 : load_base;
        ptr_nxt  = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cnt_q       <= '0;
            wr_ready_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load_start) begin
                        if (load_len != '0) begin
                            state_q    <= StLoad;
                            ptr_q      <= base_fix;
                            cnt_q      <= load_len;
                            wr_ready_q <= 1'b1;
                        end else begin
                            // Empty burst: complete immediately, nothing written.
                            state_q     <= StDone;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (wr_beat) begin
                        ptr_q <= ptr_nxt;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CntOne) begin
                            state_q     <= StDone;
                            wr_ready_q  <= 1'b0;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q    <= StIdle;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready  = wr_ready_q;
    assign load_done = load_done_q;
    assign busy      = (state_q != StIdle);

    // -----------------------------------------------------------------------
    // Storage: segment-masked writes, no reset on the array
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_beat) begin
            for (int s = 0; s < int'(NSEG); s++) begin
                if (wr_mask[s]) begin
                    mem[ptr_q][s*SEG_W +: SEG_W] <= wr_data[s*SEG_W +: SEG_W];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read pipeline
    // -----------------------------------------------------------------------
    // A load start wins over a same-cycle read, so the read is refused.
    assign rd_ready  = (state_q == StIdle) && !load_start;
    assign rd_accept = rd_req && rd_ready;

    always_comb begin
        rd_word = '0;
        if (32'(rd_addr) < DEPTH) begin
            rd_word = mem[rd_addr];
        end
    end

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // Each stage only loads when its input is valid, so the last stage keeps
    // the most recent returned word while rd_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_accept;
            if (rd_accept) begin
                dat_q[0] <= rd_word;
            end
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rd_valid = vld_q[RD_LAT-1];
    assign rd_data  = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_weight_sram_bank_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for weight_sram_bank_ctrl. Two instances share all inputs: one
// with RD_LAT=3 (main, all control outputs checked) and one with RD_LAT=1
// (read path checked). A table of per-cycle vectors covers the loader
// handshake; hand-written sequences cover reads, wrap and reset mid-load.
// ---------------------------------------------------------------------------
module tb_weight_sram_bank_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [4:0]  load_base;
    logic [5:0]  load_len;
    logic        wr_valid;
    logic [29:0] wr_data;
    logic [4:0]  wr_mask;
    logic        rd_req;
    logic [4:0]  rd_addr;

    logic        wr_ready, load_done, busy, rd_ready, rd_valid;
    logic [29:0] rd_data;
    logic        wr_ready1, load_done1, busy1, rd_ready1, rd_valid1;
    logic [29:0] rd_data1;

    weight_sram_bank_ctrl #(.DATA_W(30), .DEPTH(32), .SEG_W(6), .RD_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
        .load_len(load_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_mask(wr_mask), .load_done(load_done), .busy(busy), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    weight_sram_bank_ctrl #(.DATA_W(30), .DEPTH(32), .SEG_W(6), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
        .load_len(load_len), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data),
        .wr_mask(wr_mask), .load_done(load_done1), .busy(busy1), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_ready(rd_ready1), .rd_valid(rd_valid1), .rd_data(rd_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle vector: inputs driven at a negedge, outputs checked 1ns later.
    typedef struct {
        logic        ls;
        logic [4:0]  base;
        logic [5:0]  len;
        logic        wv;
        logic [29:0] wd;
        logic [4:0]  wm;
        logic        rq;
        logic [4:0]  ra;
        logic [4:0]  e;   // {wr_ready, load_done, busy, rd_ready, rd_valid}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ls, input logic [4:0] b, input logic [5:0] l,
                       input logic wv, input logic [29:0] wd, input logic [4:0] wm,
                       input logic rq, input logic [4:0] ra, input logic [4:0] e);
        vec_t v;
        v.ls = ls; v.base = b; v.len = l; v.wv = wv; v.wd = wd; v.wm = wm;
        v.rq = rq; v.ra = ra; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        load_start = 1'b0; load_base = '0; load_len = '0;
        wr_valid = 1'b0; wr_data = '0; wr_mask = '0;
        rd_req = 1'b0; rd_addr = '0;
    endtask

    // Last word each read port returned; rd_data must hold this value.
    logic [29:0] last3 = '0;
    logic [29:0] last1 = '0;

    logic [4:0]  rq_addr[$];
    logic [29:0] rq_exp[$];
    logic [29:0] wq[$];

    // Back-to-back reads of rq_addr, checked cycle by cycle on both ports.
    // With with_load, a 1-word load to address 8 starts the cycle after the
    // last accept; in-flight reads must still return the old data.
    task automatic read_burst(input bit with_load, input logic [29:0] new_word);
        int  n;
        bit  v3, v1;
        n = rq_addr.size();
        for (int m = 0; m < n + 4; m++) begin
            @(negedge clk);
            v3 = (m >= 3) && (m - 3 < n);
            v1 = (m >= 1) && (m - 1 < n);
            if (v3) last3 = rq_exp[m-3];
            if (v1) last1 = rq_exp[m-1];
            chk("rd_valid_lat3", {31'd0, rd_valid}, {31'd0, v3});
            chk("rd_data_lat3", {2'd0, rd_data}, {2'd0, last3});
            chk("rd_valid_lat1", {31'd0, rd_valid1}, {31'd0, v1});
            chk("rd_data_lat1", {2'd0, rd_data1}, {2'd0, last1});
            if (with_load && m == n + 2) chk("load_done_after_reads", {31'd0, load_done}, 32'd1);
            rd_req  = (m < n);
            rd_addr = (m < n) ? rq_addr[m] : 5'd0;
            if (with_load) begin
                load_start = (m == n);
                load_base  = 5'd8;
                load_len   = 6'd1;
                wr_valid   = (m == n + 1);
                wr_data    = new_word;
                wr_mask    = 5'h1F;
            end
        end
        idle_inputs();
    endtask

    // Full-mask burst with wr_valid held, words from wq.
    task automatic load_words(input logic [4:0] base);
        int n;
        n = wq.size();
        @(negedge clk);
        load_start = 1'b1; load_base = base; load_len = 6'(n);
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("wr_ready_in_burst", {31'd0, wr_ready}, 32'd1);
            chk("load_done_early", {31'd0, load_done}, 32'd0);
            wr_valid = 1'b1; wr_data = wq[i]; wr_mask = 5'h1F;
            @(negedge clk);
        end
        idle_inputs();
        chk("load_done_pulse", {31'd0, load_done}, 32'd1);
        chk("wr_ready_in_done", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
        chk("load_done_cleared", {31'd0, load_done}, 32'd0);
        chk("busy_after_load", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_rd_ready", {31'd0, rd_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("reset_load_done", {31'd0, load_done}, 32'd0);
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_rd_data", {2'd0, rd_data}, 32'd0);
        chk("reset_rd_data_lat1", {2'd0, rd_data1}, 32'd0);

        // Basic load: base 0, len 4, data 1..4
        add(1, 0, 4, 0, 30'd0, 5'h00, 0, 0, 5'b00000);
        add(0, 0, 0, 1, 30'd1, 5'h1F, 0, 0, 5'b10100);
        add(0, 0, 0, 1, 30'd2, 5'h1F, 0, 0, 5'b10100);
        add(0, 0, 0, 1, 30'd3, 5'h1F, 0, 0, 5'b10100);
        add(0, 0, 0, 1, 30'd4, 5'h1F, 0, 0, 5'b10100);
        add(0, 0, 0, 0, 30'd0, 5'h00, 0, 0, 5'b01100);
        add(0, 0, 0, 0, 30'd0, 5'h00, 0, 0, 5'b00010);
        // Preload mem[6] with a known pattern
        add(1, 6, 1, 0, 30'd0, 5'h00, 0, 0, 5'b00000);
        add(0, 0, 0, 1, 30'h15555555, 5'h1F, 0, 0, 5'b10100);
        add(0, 0, 0, 0, 30'd0, 5'h00, 0, 0, 5'b01100);
        add(0, 0, 0, 0, 30'd0, 5'h00, 0, 0, 5'b00010);
        // Backpressure and masking: base 5, len 2, wr_valid 1,0,1
        add(1, 5, 2, 0, 30'd0, 5'h00, 0, 0, 5'b00000);
        add(0, 0, 0, 1, 30'h3FFFFFFF, 5'h1F, 0, 0, 5'b10100);
        add(0, 0, 0, 0, 30'd0, 5'h00, 1, 5, 5'b10100);
        add(0, 0, 0, 1, 30'd0, 5'h01, 0, 0, 5'b10100);
        add(0, 0, 0, 0, 30'd0, 5'h00, 0, 0, 5'b01100);
        add(0, 0, 0, 0, 30'd0, 5'h00, 0, 0, 5'b00010);
        // Zero length with same-cycle read (dropped), read held through DONE
        add(1, 2, 0, 0, 30'd0, 5'h00, 1, 3, 5'b00000);
        add(0, 0, 0, 0, 30'd0, 5'h00, 1, 3, 5'b01100);
        add(0, 0, 0, 0, 30'd0, 5'h00, 0, 0, 5'b00010);
        add(0, 0, 0, 0, 30'd0, 5'h00, 0, 0, 5'b00010);
        add(0, 0, 0, 0, 30'd0, 5'h00, 0, 0, 5'b00010);

        foreach (vecs[i]) begin
            @(negedge clk);
            load_start = vecs[i].ls; load_base = vecs[i].base; load_len = vecs[i].len;
            wr_valid = vecs[i].wv; wr_data = vecs[i].wd; wr_mask = vecs[i].wm;
            rd_req = vecs[i].rq; rd_addr = vecs[i].ra;
            #1;
            chk($sformatf("vec%0d_wr_ready", i), {31'd0, wr_ready}, {31'd0, vecs[i].e[4]});
            chk($sformatf("vec%0d_load_done", i), {31'd0, load_done}, {31'd0, vecs[i].e[3]});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e[2]});
            chk($sformatf("vec%0d_rd_ready", i), {31'd0, rd_ready}, {31'd0, vecs[i].e[1]});
            chk($sformatf("vec%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].e[0]});
            chk($sformatf("vec%0d_rd_valid1", i), {31'd0, rd_valid1}, {31'd0, vecs[i].e[0]});
        end
        idle_inputs();

        // Read back the basic load; zero-length load at base 2 wrote nothing.
        rq_addr = '{5'd0, 5'd1, 5'd2, 5'd3};
        rq_exp  = '{30'd1, 30'd2, 30'd3, 30'd4};
        read_burst(1'b0, 30'd0);
        // Masked update: mem[6] low segment cleared, others kept.
        rq_addr = '{5'd5, 5'd6};
        rq_exp  = '{30'h3FFFFFFF, 30'h15555540};
        read_burst(1'b0, 30'd0);

        // Pipelined reads with a load starting right after the last accept.
        wq = '{30'h0000777, 30'h0000888, 30'h0000999};
        load_words(5'd7);
        rq_addr = '{5'd7, 5'd8, 5'd9};
        rq_exp  = '{30'h0000777, 30'h0000888, 30'h0000999};
        read_burst(1'b1, 30'h2ABCDEF);
        rq_addr = '{5'd8};
        rq_exp  = '{30'h2ABCDEF};
        read_burst(1'b0, 30'd0);

        // Wrap: base 30, len 4
        wq = '{30'h0AAAAA, 30'h0BBBBB, 30'h0CCCCC, 30'h0DDDDD};
        load_words(5'd30);
        rq_addr = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd2};
        rq_exp  = '{30'h0AAAAA, 30'h0BBBBB, 30'h0CCCCC, 30'h0DDDDD, 30'd3};
        read_burst(1'b0, 30'd0);

        // Reset mid-load: preload 10..14, then abort after 2 of 5 beats.
        wq = '{30'h100, 30'h101, 30'h102, 30'h103, 30'h104};
        load_words(5'd10);
        @(negedge clk);
        load_start = 1'b1; load_base = 5'd10; load_len = 6'd5;
        @(negedge clk);
        load_start = 1'b0; wr_valid = 1'b1; wr_data = 30'h2E0; wr_mask = 5'h1F;
        @(negedge clk);
        chk("midload_wr_ready", {31'd0, wr_ready}, 32'd1);
        wr_data = 30'h2E1;
        @(negedge clk);
        wr_data = 30'h2E2;
        rst_n = 1'b0;
        #1;
        chk("midload_reset_busy", {31'd0, busy}, 32'd0);
        chk("midload_reset_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("midload_reset_rd_data", {2'd0, rd_data}, 32'd0);
        chk("midload_reset_rd_data1", {2'd0, rd_data1}, 32'd0);
        @(negedge clk);
        chk("midload_no_done_a", {31'd0, load_done}, 32'd0);
        idle_inputs();
        rst_n = 1'b1;
        last3 = '0;
        last1 = '0;
        @(negedge clk);
        chk("midload_no_done_b", {31'd0, load_done}, 32'd0);
        chk("midload_idle", {31'd0, busy}, 32'd0);
        rq_addr = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
        rq_exp  = '{30'h2E0, 30'h2E1, 30'h102, 30'h103, 30'h104};
        read_burst(1'b0, 30'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
